// File: rtl/z16_load_store_unit_if.sv
// Execute-stage request/response channel and data-memory port of the Z16 load/store unit.
// master = requester and memory side, slave = the load/store unit.
interface z16_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic        mem_wen;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_addr, mem_wen, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/z16_load_store_unit.sv
// Z16 load/store unit: one request at a time, byte loads with extension,
// byte stores by read-modify-write, alignment/range checks, valid/ready response.
module z16_load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  z16_load_store_unit_if.slave bus,
  output logic [1:0]           o_dbg_state
);
  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // the request is accepted only in IDLE, and the response holds until resp_ready.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [16:0] ADDR_LIMIT = 17'(2 * MEM_WORDS);

  state_e      state_q, state_d;
  logic        we_q, byte_q, signed_q;
  logic [15:0] addr_q;
  logic [15:0] resp_data_q;
  logic        resp_err_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;

  logic        addr_err;
  logic [7:0]  rd_lane;
  logic [15:0] load_val;
  logic [15:0] merged;

  assign addr_err = (!byte_q && addr_q[0]) || ({1'b0, addr_q} >= ADDR_LIMIT);
  assign rd_lane  = addr_q[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
  assign load_val = !byte_q   ? bus.mem_rdata :
                    signed_q  ? {{8{rd_lane[7]}}, rd_lane} : {8'h00, rd_lane};
  // mem_wdata_q still holds the raw store data here, so its low byte is the new lane.
  assign merged   = addr_q[0] ? {mem_wdata_q[7:0], bus.mem_rdata[7:0]}
                              : {bus.mem_rdata[15:8], mem_wdata_q[7:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = ST_EXEC;
      ST_EXEC:  state_d = (we_q && byte_q && !addr_err) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = !i_rst && (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.mem_wen    = !i_rst && (((state_q == ST_EXEC) && we_q && !byte_q && !addr_err) ||
                                (state_q == ST_WRITE));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      addr_q      <= 16'h0000;
      resp_data_q <= 16'h0000;
      resp_err_q  <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q       <= bus.req_we;
            byte_q     <= bus.req_byte;
            signed_q   <= bus.req_signed;
            addr_q     <= bus.req_addr;
            // Address is presented from the EXEC cycle on so the read data is ready there.
            mem_addr_q <= {bus.req_addr[15:1], 1'b0};
            if (bus.req_we) mem_wdata_q <= bus.req_wdata;
          end
        end
        ST_EXEC: begin
          resp_err_q  <= addr_err;
          resp_data_q <= (addr_err || we_q) ? 16'h0000 : load_val;
          if (we_q && byte_q && !addr_err) mem_wdata_q <= merged;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign o_dbg_state   = state_q;
endmodule
